mem_port_arbiter: RTL and testbench

//  N-requester arbiter for the single shared SRAM/UART memory port. Generalises the fixed IF/MEM mux in front of the MMU.

---
 rtl/mem_port_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single SRAM/UART memory port between NUM_PORTS requesters
//   (IF, MEM, and later DMA/debug). One request is latched at a time and
//   driven to the MMU with a req/ack handshake. When the access finishes,
//   the owning port gets a one-cycle done pulse, or an err pulse if the
//   memory never answered. Read data is captured into rdata.
//
//   Port summary:
//     clk, rst            clock, asynchronous active-high reset
//     req_valid/we        per-port request and write flag
//     req_addr/wdata/be   flattened per-port buses, port i uses slice i
//     req_done/req_err    per-port one-cycle completion / timeout pulses
//     req_stall           per-port hold signal for the pipeline stages
//     rdata               read data of the last completed read
//     mem_req/we/addr/... latched access presented to the MMU
//     mem_ack/mem_rdata   MMU completion handshake and read data
//
//   Build option: define ARB_ROUND_ROBIN_EN to select round-robin
//   arbitration. Without it, the lowest requesting index always wins.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0]              req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]       req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]       req_wdata,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0]   req_be,
    output logic [NUM_PORTS-1:0]              req_done,
    output logic [NUM_PORTS-1:0]              req_err,
    output logic [NUM_PORTS-1:0]              req_stall,
    output logic [DATA_W-1:0]                 rdata,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    output logic [DATA_W/8-1:0]               mem_be,
    input  logic                              mem_ack,
    input  logic [DATA_W-1:0]                 mem_rdata
);

    localparam int BE_W   = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] done_q, done_d;
    logic [NUM_PORTS-1:0] err_q, err_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]      mem_be_q, mem_be_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 win_found;
    logic [PORT_W-1:0]    win_idx;
    logic                 timeout_hit;
`ifdef ARB_ROUND_ROBIN_EN
    logic [PORT_W-1:0]    ptr_q, ptr_d;
    logic [PORT_W-1:0]    gidx_q, gidx_d;
    logic [PORT_W-1:0]    ptr_next;
    logic [PORT_W-1:0]    scan;
`endif

    // Winner selection. Round-robin scans upward from the pointer with
    // wrap-around. Fixed priority lets the lowest index win, so the MEM
    // stage on port 0 is never starved by instruction fetch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef ARB_ROUND_ROBIN_EN
        scan = ptr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan = PORT_W'((int'(ptr_q) + k) % NUM_PORTS);
            if (!win_found && req_valid[scan]) begin
                win_found = 1'b1;
                win_idx   = scan;
            end
        end
`else
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                win_found = 1'b1;
                win_idx   = PORT_W'(k);
            end
        end
`endif
    end

    // The timeout fires on the last allowed BUSY cycle. The TIMEOUT != 0
    // term disables the timeout entirely for memories that may stall forever.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef ARB_ROUND_ROBIN_EN
    assign ptr_next = (gidx_q == PORT_W'(NUM_PORTS - 1)) ? '0 : gidx_q + 1'b1;
`endif

    // Next-state logic. Done/err are computed here and registered, so they
    // appear one cycle after the ack/timeout edge. The same edge drops mem_req.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        err_d       = '0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    mem_we_d    = req_we[win_idx];
                    mem_addr_d  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    mem_wdata_d = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                    mem_be_d    = req_be[int'(win_idx)*BE_W +: BE_W];
                    grant_d     = NUM_PORTS'(1) << win_idx;
                    cnt_d       = '0;
                    state_d     = BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                    gidx_d      = win_idx;
`endif
                end
            end
            BUSY: begin
                // Saturating counter, so a long stall can never wrap around.
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Ack is checked first, so it wins when it lands on the timeout cycle.
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    done_d  = grant_q;
                    state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = ptr_next;
`endif
                end else if (timeout_hit) begin
                    err_d   = grant_q;
                    state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = ptr_next;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        mem_req_d = (state_d == BUSY);
    end

    // State and output registers. Reset is asynchronous, so mem_req drops
    // as soon as rst rises and any in-flight access is dropped silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= '0;
            gidx_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
`endif
        end
    end

    assign req_done  = done_q;
    assign req_err   = err_q;
    assign req_stall = req_valid & ~done_q & ~err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two ports, 32-bit buses, TIMEOUT = 4.
// A transaction-level reference model predicts every output each cycle.
// Directed sequences, a vector table and a randomized phase drive the DUT.
module tb_mem_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NP-1:0]       req_valid;
    logic [NP-1:0]       req_we;
    logic [NP*AW-1:0]    req_addr;
    logic [NP*DW-1:0]    req_wdata;
    logic [NP*BW-1:0]    req_be;
    logic [NP-1:0]       req_done;
    logic [NP-1:0]       req_err;
    logic [NP-1:0]       req_stall;
    logic [DW-1:0]       rdata;
    logic                mem_req;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [BW-1:0]       mem_be;
    logic                mem_ack;
    logic [DW-1:0]       mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_stall (req_stall),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory responder settings: ack_mode >= 0 acks when the access has been
    // outstanding that many cycles, -1 never acks, -2 acks at random.
    int          ack_mode;
    bit          rand_rdata;
    logic [31:0] fixed_rdata;

    // Reference model: the access in flight plus the pulses owed this cycle.
    bit          m_busy;
    int          m_port;
    int          m_age;
    int          m_ptr;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    logic [1:0]  m_done;
    logic [1:0]  m_err;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack;
        logic [31:0] mem_rd;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[6];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_port  = 0;
        m_age   = 0;
        m_ptr   = 0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        m_rdata = '0;
        m_done  = '0;
        m_err   = '0;
    endtask

    function automatic int pick();
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NP; k++) begin
            if (req_valid[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
        end
`else
        for (int k = 0; k < NP; k++) begin
            if (req_valid[k]) return k;
        end
`endif
        return -1;
    endfunction

    // Advance the model by one clock, using the inputs present before the edge.
    task automatic model_next();
        int g;
        m_done = '0;
        m_err  = '0;
        if (!m_busy) begin
            g = pick();
            if (g >= 0) begin
                m_busy  = 1'b1;
                m_port  = g;
                m_age   = 0;
                m_we    = req_we[g];
                m_addr  = req_addr[g*AW +: AW];
                m_wdata = req_wdata[g*DW +: DW];
                m_be    = req_be[g*BW +: BW];
            end
        end else if (mem_ack) begin
            if (!m_we) m_rdata = mem_rdata;
            m_done[m_port] = 1'b1;
            m_busy = 1'b0;
            m_ptr  = (m_port + 1) % NP;
        end else if (m_age == TO - 1) begin
            m_err[m_port] = 1'b1;
            m_busy = 1'b0;
            m_ptr  = (m_port + 1) % NP;
        end else begin
            m_age++;
        end
    endtask

    // One clock cycle: respond as memory, compare all outputs with the model,
    // advance the model, then move to just after the next rising edge.
    task automatic applyStimulus();
        if (ack_mode == -2) mem_ack = m_busy && ($urandom_range(0, 2) == 0);
        else                mem_ack = m_busy && (m_age == ack_mode);
        mem_rdata = rand_rdata ? $urandom() : fixed_rdata;
        #1;
        checkOutput("mem_req",   64'(mem_req),   64'(m_busy));
        checkOutput("mem_we",    64'(mem_we),    64'(m_we));
        checkOutput("mem_addr",  64'(mem_addr),  64'(m_addr));
        checkOutput("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        checkOutput("mem_be",    64'(mem_be),    64'(m_be));
        checkOutput("req_done",  64'(req_done),  64'(m_done));
        checkOutput("req_err",   64'(req_err),   64'(m_err));
        checkOutput("rdata",     64'(rdata),     64'(m_rdata));
        checkOutput("req_stall", 64'(req_stall), 64'(req_valid & ~m_done & ~m_err));
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst     = 1'b1;
        mem_ack = 1'b0;
        #1;
        checkOutput("rst_mem_req", 64'(mem_req),  64'(0));
        checkOutput("rst_done",    64'(req_done), 64'(0));
        checkOutput("rst_err",     64'(req_err),  64'(0));
        checkOutput("rst_rdata",   64'(rdata),    64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Run cycles until a done or err pulse. A missing completion within the bound is a failure.
    task automatic waitCompletion(input int bound, output int cyc, output logic [1:0] d,
                                  output logic [1:0] e, output int hi);
        cyc = 0;
        d   = '0;
        e   = '0;
        hi  = 0;
        while (cyc < bound && d == 0 && e == 0) begin
            applyStimulus();
            cyc++;
            if (mem_req) hi++;
            d = req_done;
            e = req_err;
        end
        if (d == 0 && e == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL completion_wait: got none after %0d cycles, expected done or err", bound);
        end
    endtask

    task automatic newRequest(input int p);
        req_valid[p]           = 1'b1;
        req_we[p]              = 1'($urandom_range(0, 1));
        req_addr[p*AW +: AW]   = $urandom();
        req_wdata[p*DW +: DW]  = $urandom();
        req_be[p*BW +: BW]     = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int          cyc;
        int          hi;
        logic [1:0]  d;
        logic [1:0]  e;
        int          cnt[2];
        int          order[$];
        int          p;

        rst         = 1'b1;
        req_valid   = '0;
        req_we      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        ack_mode    = -1;
        rand_rdata  = 1'b0;
        fixed_rdata = '0;
        model_reset();

        tbl[0] = '{0, 1'b1, 32'h80400000, 32'h12345678, 4'b0001, 1, 32'h11111111, 3, 1'b0, 32'hDEADBEEF};
        tbl[1] = '{1, 1'b0, 32'h00001000, 32'h00000000, 4'b1111, 0, 32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D};
        tbl[2] = '{0, 1'b0, 32'h00002004, 32'h00000000, 4'b1111, 3, 32'hA5A5A5A5, 5, 1'b0, 32'hA5A5A5A5};
        tbl[3] = '{1, 1'b1, 32'h0000300C, 32'hFFFF0000, 4'b1100, -1, 32'h22222222, 5, 1'b1, 32'hA5A5A5A5};
        tbl[4] = '{0, 1'b0, 32'h00000040, 32'h00000000, 4'b1111, -1, 32'h33333333, 5, 1'b1, 32'hA5A5A5A5};
        tbl[5] = '{1, 1'b0, 32'h7FFFFFFC, 32'h00000000, 4'b1111, 2, 32'h01234567, 4, 1'b0, 32'h01234567};

        repeat (2) @(posedge clk);
        doReset();
        $display("[TB] reset released");

        // Single read on port 1, acked on the third mem_req cycle.
        req_valid   = 2'b10;
        req_we      = 2'b00;
        req_addr[63:32] = 32'h80000010;
        ack_mode    = 2;
        fixed_rdata = 32'hDEADBEEF;
        applyStimulus();
        for (int c = 1; c <= 4; c++) begin
            checkOutput("t1_mem_req", 64'(mem_req),      64'(c <= 3));
            checkOutput("t1_stall1",  64'(req_stall[1]), 64'(c <= 3));
            checkOutput("t1_done",    64'(req_done),     (c == 4) ? 64'h2 : 64'h0);
            if (c == 4) begin
                checkOutput("t1_rdata", 64'(rdata), 64'hDEADBEEF);
                req_valid = '0;
            end
            applyStimulus();
        end

        // Single-access vectors: write, reads, ack on the timeout cycle, timeouts.
        for (int i = 0; i < 6; i++) begin
            p = tbl[i].port;
            req_valid               = '0;
            req_we[p]               = tbl[i].we;
            req_addr[p*AW +: AW]    = tbl[i].addr;
            req_wdata[p*DW +: DW]   = tbl[i].wdata;
            req_be[p*BW +: BW]      = tbl[i].be;
            req_valid[p]            = 1'b1;
            ack_mode                = tbl[i].ack;
            fixed_rdata             = tbl[i].mem_rd;
            waitCompletion(20, cyc, d, e, hi);
            checkOutput($sformatf("vec%0d_cycle", i), 64'(cyc), 64'(tbl[i].exp_cyc));
            checkOutput($sformatf("vec%0d_done", i),  64'(d), tbl[i].exp_err ? 64'h0 : 64'(1 << p));
            checkOutput($sformatf("vec%0d_err", i),   64'(e), tbl[i].exp_err ? 64'(1 << p) : 64'h0);
            checkOutput($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(tbl[i].exp_rdata));
            req_valid = '0;
        end

        // Timeout with no ack, then a normal access afterwards.
        req_valid       = 2'b10;
        req_we          = 2'b00;
        req_addr[63:32] = 32'h00005000;
        ack_mode        = -1;
        waitCompletion(20, cyc, d, e, hi);
        checkOutput("t4_err",       64'(e),   64'h2);
        checkOutput("t4_done",      64'(d),   64'h0);
        checkOutput("t4_req_cycles", 64'(hi), 64'(TO));
        req_addr[63:32] = 32'h00005004;
        ack_mode        = 1;
        waitCompletion(20, cyc, d, e, hi);
        checkOutput("t4_next_done",  64'(d),   64'h2);
        checkOutput("t4_next_cycle", 64'(cyc), 64'h3);
        req_valid = '0;

        // Reset in the second BUSY cycle, then a fresh access from the held request.
        req_valid       = 2'b01;
        req_addr[31:0]  = 32'h00000100;
        ack_mode        = -1;
        applyStimulus();
        applyStimulus();
        checkOutput("t5_busy", 64'(mem_req), 64'h1);
        doReset();
        applyStimulus();
        checkOutput("t5_restart_req",  64'(mem_req),  64'h1);
        checkOutput("t5_restart_addr", 64'(mem_addr), 64'h100);
        ack_mode = 0;
        waitCompletion(20, cyc, d, e, hi);
        checkOutput("t5_done", 64'(d), 64'h1);
        req_valid = '0;

        // Contention: both ports issue four accesses each.
        doReset();
        cnt[0]          = 0;
        cnt[1]          = 0;
        req_we          = 2'b00;
        req_addr[31:0]  = 32'h00000000;
        req_addr[63:32] = 32'h00010000;
        req_valid       = 2'b11;
        ack_mode        = 0;
        for (int c = 0; c < 80 && (cnt[0] < 4 || cnt[1] < 4); c++) begin
            applyStimulus();
            for (int q = 0; q < NP; q++) begin
                if (req_done[q]) begin
                    order.push_back(q);
                    cnt[q]++;
                    if (cnt[q] == 4) req_valid[q] = 1'b0;
                    else req_addr[q*AW +: AW] = req_addr[q*AW +: AW] + 32'd4;
                end
            end
        end
        checkOutput("t3_grants", 64'(order.size()), 64'd8);
        for (int i = 0; i < order.size() && i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            checkOutput($sformatf("t3_grant%0d", i), 64'(order[i]), 64'(i % 2));
`else
            checkOutput($sformatf("t3_grant%0d", i), 64'(order[i]), (i < 4) ? 64'h0 : 64'h1);
`endif
        end
        req_valid = '0;

        // Randomized traffic against the reference model.
        ack_mode   = -2;
        rand_rdata = 1'b1;
        for (int c = 0; c < 400; c++) begin
            applyStimulus();
            for (int q = 0; q < NP; q++) begin
                if (req_valid[q] && (m_done[q] || m_err[q])) begin
                    if ($urandom_range(0, 1) == 1) newRequest(q);
                    else req_valid[q] = 1'b0;
                end else if (!req_valid[q]) begin
                    if ($urandom_range(0, 3) == 0) newRequest(q);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[q] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_wdata[q*DW +: DW] = $urandom();
                end
            end
        end
        req_valid = '0;
        ack_mode  = 0;
        repeat (4) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
